// File: rtl/frame_ingest_pp.sv
// frame_ingest_pp: sync-framed UART pixel loader writing CHW-ordered Q(FRAC_BITS) pixels into ping-pong IFMAP banks.
// Optional feature macro FRAME_CHECKSUM_EN: trailing mod-256 checksum byte, CHECK state and cksum_err output.
module frame_ingest_pp #(
  parameter int         DATA_WIDTH     = 16,
  parameter int         FRAC_BITS      = 7,
  parameter int         IMG_SIZE       = 28,
  parameter int         IN_CHANNELS    = 1,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 500_000,
  localparam int        AW             = $clog2(IN_CHANNELS * IMG_SIZE * IMG_SIZE)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_dv,
  input  logic [7:0]            rx_byte,
  output logic                  wr_en,
  output logic                  wr_bank,
  output logic [AW-1:0]         wr_addr,
  output logic [DATA_WIDTH-1:0] wr_din,
  output logic                  frame_valid,
  output logic                  frame_bank,
  input  logic                  frame_ack,
  output logic                  overrun,
  output logic                  timeout_err,
`ifdef FRAME_CHECKSUM_EN
  output logic                  cksum_err,
`endif
  output logic [15:0]           frame_count
);

  localparam int TOTAL    = IN_CHANNELS * IMG_SIZE * IMG_SIZE;
`ifdef FRAME_CHECKSUM_EN
  localparam int DROP_LEN = TOTAL + 1;
`else
  localparam int DROP_LEN = TOTAL;
`endif
  localparam int CHW = (IN_CHANNELS > 1) ? $clog2(IN_CHANNELS) : 1;
  localparam int PW  = (IMG_SIZE > 1) ? $clog2(IMG_SIZE) : 1;
  localparam int TW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int CVW = FRAC_BITS + 9;

  typedef enum logic [2:0] {
    S_SYNC,
    S_LOAD,
    S_DROP,
`ifdef FRAME_CHECKSUM_EN
    S_CHECK,
`endif
    S_COMMIT
  } state_t;

  state_t          state, state_n;
  logic            cur_bank, bank_n;
  logic [CHW-1:0]  ch, ch_n;
  logic [PW-1:0]   row, row_n, col, col_n;
  logic [AW:0]     drop_cnt, drop_n;
  logic [TW-1:0]   idle_cnt, idle_n;
  logic            wr_en_n, overrun_n, timeout_n, in_frame, commit, pop;
  logic [1:0]      bank_full, busy, free;
  logic            fifo_q0, fifo_q1;
  logic [1:0]      fifo_cnt;
  logic            last_ch, last_col, last_row;
  logic [AW-1:0]   addr;
  logic [CVW-1:0]  conv_num, conv;
`ifdef FRAME_CHECKSUM_EN
  logic [7:0]      csum, csum_n;
  logic            cksum_n;
`endif

  assign commit   = (state == S_COMMIT);
  assign pop      = frame_ack && (fifo_cnt != 2'd0);
  // The bank committing this cycle is still flagged free in bank_full; keep it out of the free set.
  assign busy     = commit ? (2'b01 << cur_bank) : 2'b00;
  assign free     = ~bank_full & ~busy;
  assign last_ch  = (ch == CHW'(IN_CHANNELS - 1));
  assign last_col = (col == PW'(IMG_SIZE - 1));
  assign last_row = (row == PW'(IMG_SIZE - 1));
  assign addr     = (AW'(ch) * AW'(IMG_SIZE) + AW'(row)) * AW'(IMG_SIZE) + AW'(col);
  assign conv_num = (CVW'(rx_byte) << FRAC_BITS) + CVW'(127);
  assign conv     = conv_num / CVW'(255);

  assign frame_valid = (fifo_cnt != 2'd0);
  assign frame_bank  = fifo_q0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_SYNC;
      cur_bank <= 1'b0;
      ch       <= '0;
      row      <= '0;
      col      <= '0;
      drop_cnt <= '0;
      idle_cnt <= '0;
`ifdef FRAME_CHECKSUM_EN
      csum     <= '0;
`endif
    end else begin
      state    <= state_n;
      cur_bank <= bank_n;
      ch       <= ch_n;
      row      <= row_n;
      col      <= col_n;
      drop_cnt <= drop_n;
      idle_cnt <= idle_n;
`ifdef FRAME_CHECKSUM_EN
      csum     <= csum_n;
`endif
    end
  end

  always_comb begin
    state_n   = state;
    bank_n    = cur_bank;
    ch_n      = ch;
    row_n     = row;
    col_n     = col;
    drop_n    = drop_cnt;
    idle_n    = idle_cnt;
    wr_en_n   = 1'b0;
    overrun_n = 1'b0;
    timeout_n = 1'b0;
    in_frame  = 1'b0;
`ifdef FRAME_CHECKSUM_EN
    csum_n    = csum;
    cksum_n   = 1'b0;
`endif
    unique case (state)
      S_SYNC, S_COMMIT: begin
        state_n = S_SYNC;
        if (rx_dv && (rx_byte == SYNC_BYTE)) begin
          ch_n   = '0;
          row_n  = '0;
          col_n  = '0;
          drop_n = '0;
          idle_n = '0;
`ifdef FRAME_CHECKSUM_EN
          csum_n = '0;
`endif
          if (free != 2'b00) begin
            bank_n  = free[0] ? 1'b0 : 1'b1;
            state_n = S_LOAD;
          end else begin
            overrun_n = 1'b1;
            state_n   = S_DROP;
          end
        end
      end
      S_LOAD: begin
        in_frame = 1'b1;
        if (rx_dv) begin
          wr_en_n = 1'b1;
          idle_n  = '0;
`ifdef FRAME_CHECKSUM_EN
          csum_n  = csum + rx_byte;
`endif
          if (last_ch) begin
            ch_n = '0;
            if (last_col) begin
              col_n = '0;
              if (last_row) begin
                row_n = '0;
`ifdef FRAME_CHECKSUM_EN
                state_n = S_CHECK;
`else
                state_n = S_COMMIT;
`endif
              end else begin
                row_n = row + PW'(1);
              end
            end else begin
              col_n = col + PW'(1);
            end
          end else begin
            ch_n = ch + CHW'(1);
          end
        end
      end
      S_DROP: begin
        in_frame = 1'b1;
        if (rx_dv) begin
          idle_n = '0;
          if (drop_cnt == (AW+1)'(DROP_LEN - 1)) state_n = S_SYNC;
          else                                   drop_n  = drop_cnt + (AW+1)'(1);
        end
      end
`ifdef FRAME_CHECKSUM_EN
      S_CHECK: begin
        in_frame = 1'b1;
        if (rx_dv) begin
          idle_n = '0;
          if (rx_byte == csum) begin
            state_n = S_COMMIT;
          end else begin
            cksum_n = 1'b1;
            state_n = S_SYNC;
          end
        end
      end
`endif
      default: state_n = S_SYNC;
    endcase
    if (in_frame && !rx_dv && (TIMEOUT_CYCLES != 0)) begin
      if (idle_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
        timeout_n = 1'b1;
        state_n   = S_SYNC;
      end else begin
        idle_n = idle_cnt + TW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_en       <= 1'b0;
      wr_bank     <= 1'b0;
      wr_addr     <= '0;
      wr_din      <= '0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
      frame_count <= '0;
`ifdef FRAME_CHECKSUM_EN
      cksum_err   <= 1'b0;
`endif
    end else begin
      wr_en       <= wr_en_n;
      overrun     <= overrun_n;
      timeout_err <= timeout_n;
`ifdef FRAME_CHECKSUM_EN
      cksum_err   <= cksum_n;
`endif
      if (wr_en_n) begin
        wr_bank <= cur_bank;
        wr_addr <= addr;
        wr_din  <= DATA_WIDTH'(conv);
      end
      if (commit) frame_count <= frame_count + 16'd1;
    end
  end

  // Two-entry commit FIFO plus per-bank full flags; push and pop may coincide.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bank_full <= '0;
      fifo_q0   <= 1'b0;
      fifo_q1   <= 1'b0;
      fifo_cnt  <= '0;
    end else begin
      if (pop)    bank_full[fifo_q0]  <= 1'b0;
      if (commit) bank_full[cur_bank] <= 1'b1;
      case ({commit, pop})
        2'b10: begin
          if (fifo_cnt == 2'd0) fifo_q0 <= cur_bank;
          else                  fifo_q1 <= cur_bank;
          fifo_cnt <= fifo_cnt + 2'd1;
        end
        2'b01: begin
          fifo_q0  <= fifo_q1;
          fifo_cnt <= fifo_cnt - 2'd1;
        end
        2'b11: begin
          if (fifo_cnt == 2'd1) begin
            fifo_q0 <= cur_bank;
          end else begin
            fifo_q0 <= fifo_q1;
            fifo_q1 <= cur_bank;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_ingest_pp.sv
// Self-checking bench for frame_ingest_pp: frame-level reference model compared every cycle, plus literal pins.
module tb_frame_ingest_pp;
  localparam int IMG   = 3;
  localparam int CH    = 2;
  localparam int TOTAL = CH * IMG * IMG;
  localparam int TO    = 100;
  localparam int FRAC  = 7;
  localparam int AW    = $clog2(TOTAL);
`ifdef FRAME_CHECKSUM_EN
  localparam int DROP_LEN = TOTAL + 1;
`else
  localparam int DROP_LEN = TOTAL;
`endif
  localparam int M_SYNC = 0, M_LOAD = 1, M_DROP = 2, M_CHECK = 3, M_COMMIT = 4;

  logic clk = 1'b0;
  logic reset, rx_dv, frame_ack;
  logic [7:0] rx_byte;
  logic wr_en, wr_bank, frame_valid, frame_bank, overrun, timeout_err;
  logic [AW-1:0] wr_addr;
  logic [15:0] wr_din, frame_count;
`ifdef FRAME_CHECKSUM_EN
  logic cksum_err;
`endif

  int errors = 0, checks = 0;
  int m_mode, m_k, m_idle, m_bank, m_sum, m_count;
  int full [2];
  int q [$];
  bit exp_wr_en, exp_ovr, exp_to, exp_ck;
  int exp_bank, exp_addr, exp_din;
  logic [15:0] mem [2][32];
  int wr_cnt = 0, ovr_cnt = 0, to_cnt = 0, ck_cnt = 0, to_at;

  frame_ingest_pp #(
    .DATA_WIDTH(16), .FRAC_BITS(FRAC), .IMG_SIZE(IMG), .IN_CHANNELS(CH),
    .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TO)
  ) u_dut (
    .clk(clk), .reset(reset), .rx_dv(rx_dv), .rx_byte(rx_byte),
    .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_din(wr_din),
    .frame_valid(frame_valid), .frame_bank(frame_bank), .frame_ack(frame_ack),
    .overrun(overrun), .timeout_err(timeout_err),
`ifdef FRAME_CHECKSUM_EN
    .cksum_err(cksum_err),
`endif
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  // Reference model: frame-level view (byte index -> CHW address), FIFO as a queue.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_mode = M_SYNC; m_k = 0; m_idle = 0; m_bank = 0; m_sum = 0; m_count = 0;
      full[0] = 0; full[1] = 0; q.delete();
      exp_wr_en = 0; exp_ovr = 0; exp_to = 0; exp_ck = 0;
      exp_bank = 0; exp_addr = 0; exp_din = 0;
    end else begin
      exp_wr_en = 0; exp_ovr = 0; exp_to = 0; exp_ck = 0;
      if (m_mode == M_COMMIT) begin
        q.push_back(m_bank); full[m_bank] = 1; m_count++; m_mode = M_SYNC;
      end
      if (rx_dv) begin
        m_idle = 0;
        case (m_mode)
          M_SYNC: if (rx_byte == 8'hA5) begin
            m_k = 0; m_sum = 0;
            if (full[0] == 0)      begin m_bank = 0; m_mode = M_LOAD; end
            else if (full[1] == 0) begin m_bank = 1; m_mode = M_LOAD; end
            else begin exp_ovr = 1; m_mode = M_DROP; end
          end
          M_LOAD: begin
            exp_wr_en = 1;
            exp_bank  = m_bank;
            exp_addr  = (m_k % CH) * IMG * IMG + m_k / CH;
            exp_din   = (int'(rx_byte) * (1 << FRAC) + 127) / 255;
            m_sum     = (m_sum + int'(rx_byte)) % 256;
            m_k++;
`ifdef FRAME_CHECKSUM_EN
            if (m_k == TOTAL) m_mode = M_CHECK;
`else
            if (m_k == TOTAL) m_mode = M_COMMIT;
`endif
          end
          M_DROP: begin
            m_k++;
            if (m_k == DROP_LEN) m_mode = M_SYNC;
          end
          M_CHECK: begin
            if (int'(rx_byte) == m_sum) m_mode = M_COMMIT;
            else begin exp_ck = 1; m_mode = M_SYNC; end
          end
          default: ;
        endcase
      end else if (m_mode == M_LOAD || m_mode == M_DROP || m_mode == M_CHECK) begin
        m_idle++;
        if (m_idle == TO) begin exp_to = 1; m_mode = M_SYNC; end
      end
      if (frame_ack && q.size() != 0) begin
        full[q[0]] = 0;
        void'(q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("wr_en", int'(wr_en), int'(exp_wr_en));
      if (exp_wr_en) begin
        chk("wr_bank", int'(wr_bank), exp_bank);
        chk("wr_addr", int'(wr_addr), exp_addr);
        chk("wr_din", int'(wr_din), exp_din);
      end
      chk("frame_valid", int'(frame_valid), int'(q.size() != 0));
      if (q.size() != 0) chk("frame_bank", int'(frame_bank), q[0]);
      chk("frame_count", int'(frame_count), m_count % 65536);
      chk("overrun", int'(overrun), int'(exp_ovr));
      chk("timeout_err", int'(timeout_err), int'(exp_to));
`ifdef FRAME_CHECKSUM_EN
      chk("cksum_err", int'(cksum_err), int'(exp_ck));
`endif
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (wr_en) begin mem[wr_bank][wr_addr] = wr_din; wr_cnt++; end
      if (overrun) ovr_cnt++;
      if (timeout_err) to_cnt++;
`ifdef FRAME_CHECKSUM_EN
      if (cksum_err) ck_cnt++;
`endif
    end
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk); rx_dv = 1'b1; rx_byte = b; frame_ack = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(negedge clk); rx_dv = 1'b0; frame_ack = 1'b0; end
  endtask

  task automatic ack();
    @(negedge clk); rx_dv = 1'b0; frame_ack = 1'b1;
  endtask

  function automatic logic [7:0] fbyte(input int kind, input int k);
    case (kind)
      0:       return (k % 2 == 0) ? 8'hFF : 8'h00;
      1:       return 8'(k);
      default: return 8'(k * 7 + 3);
    endcase
  endfunction

  task automatic send_frame(input int kind, input bit bad_sum);
    logic [7:0] s;
    s = 8'h00;
    for (int k = 0; k < TOTAL; k++) begin
      s = s + fbyte(kind, k);
      send(fbyte(kind, k));
    end
`ifdef FRAME_CHECKSUM_EN
    send(bad_sum ? s + 8'd1 : s);
`else
    if (bad_sum) s = 8'h00;
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int b = 0; b < 2; b++) for (int a = 0; a < 32; a++) mem[b][a] = 16'hFFFF;
    reset = 1'b1; rx_dv = 1'b0; rx_byte = 8'h00; frame_ack = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_frame_valid", int'(frame_valid), 0);
    chk("rst_frame_count", int'(frame_count), 0);
    chk("rst_overrun", int'(overrun), 0);
    @(negedge clk); reset = 1'b0;

    // Junk before sync, then frame to bank0
    send(8'h00); send(8'h12); send(8'hA5); send_frame(0, 0); idle(3); #1;
    chk("f1_valid", int'(frame_valid), 1);
    chk("f1_bank", int'(frame_bank), 0);
    chk("f1_count", int'(frame_count), 1);
    chk("f1_writes", wr_cnt, 18);
    chk("f1_mem0", int'(mem[0][0]), 128);
    chk("f1_mem8", int'(mem[0][8]), 128);
    chk("f1_mem9", int'(mem[0][9]), 0);
    chk("f1_mem17", int'(mem[0][17]), 0);

    send(8'hA5); send_frame(1, 0); idle(3); #1;
    chk("f2_count", int'(frame_count), 2);
    chk("f2_head", int'(frame_bank), 0);
    chk("f2_mem10", int'(mem[1][10]), 2);
    chk("f2_mem8", int'(mem[1][8]), 8);
    chk("f2_mem17", int'(mem[1][17]), 9);

    // Both banks full: overrun and dropped frame
    send(8'hA5); send_frame(2, 0); idle(3); #1;
    chk("ovr_pulses", ovr_cnt, 1);
    chk("ovr_no_writes", wr_cnt, 36);
    chk("ovr_count", int'(frame_count), 2);
    ack(); idle(2);
    send(8'hA5); send_frame(2, 0); idle(3); #1;
    chk("f3_count", int'(frame_count), 3);
    chk("f3_head", int'(frame_bank), 1);
    chk("f3_mem0", int'(mem[0][0]), 2);

    // Drain, then one extra ack on an empty FIFO
    ack(); ack(); ack(); idle(2); #1;
    chk("drain_valid", int'(frame_valid), 0);

    // Ack of bank0 coincides with bank1 commit
    send(8'hA5); send_frame(0, 0); idle(2);
    send(8'hA5); send_frame(1, 0); ack(); idle(2); #1;
    chk("coinc_valid", int'(frame_valid), 1);
    chk("coinc_bank", int'(frame_bank), 1);
    chk("coinc_count", int'(frame_count), 5);

    // Timeout after 5 pixel bytes, then reload bank0 from address 0
    ack(); idle(2);
    send(8'hA5);
    repeat (5) send(8'hFF);
    to_at = 0;
    for (int n = 1; n <= 200 && to_at == 0; n++) begin
      idle(1); @(posedge clk); #1;
      if (timeout_err) to_at = n;
    end
    chk("timeout_idle_clks", to_at, 100);
    send(8'hA5); send_frame(1, 0); idle(3); #1;
    chk("to_pulses", to_cnt, 1);
    chk("reload_mem0", int'(mem[0][0]), 0);
    chk("reload_mem1", int'(mem[0][1]), 1);
    chk("reload_bank", int'(frame_bank), 0);
    chk("reload_count", int'(frame_count), 6);

`ifdef FRAME_CHECKSUM_EN
    send(8'hA5); send_frame(1, 1); idle(3); #1;
    chk("ck_pulses", ck_cnt, 1);
    chk("ck_count", int'(frame_count), 6);
    chk("ck_bank", int'(frame_bank), 0);
    send(8'hA5); send_frame(1, 0); idle(3); #1;
    chk("ck_ok_count", int'(frame_count), 7);
`endif

    // Asynchronous reset in the middle of a frame
    send(8'hA5); send(8'hFF); send(8'hFF);
    @(posedge clk); #2;
    chk("pre_reset_wr_en", int'(wr_en), 1);
    reset = 1'b1; rx_dv = 1'b0;
    #1;
    chk("arst_wr_en", int'(wr_en), 0);
    chk("arst_wr_din", int'(wr_din), 0);
    chk("arst_frame_valid", int'(frame_valid), 0);
    chk("arst_frame_count", int'(frame_count), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    send(8'hA5); send_frame(0, 0); idle(3); #1;
    chk("post_rst_count", int'(frame_count), 1);
    chk("post_rst_bank", int'(frame_bank), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
